// File: rtl/width_pack_arb_pkg.sv
// Shared types and constants for the byte-pair packing arbiter.
// Timeout padding is compiled in with WIDTH_PACK_ARB_TIMEOUT_EN.
package width_pack_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_t;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    function automatic int src_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/width_pack_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr.
// Wraps with an explicit compare so non-power-of-2 counts work.
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         found
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/width_pack_arbiter.sv
// Round-robin arbiter feeding one 8-to-16 packer; grant held per word.
// WIDTH_PACK_ARB_TIMEOUT_EN adds stall timeout with zero-byte padding.
module width_pack_arbiter
    import width_pack_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int TIMEOUT_CYC = 15,
    localparam int SRC_W       = src_w(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               valid_out,
    output logic [15:0]        data_out,
    output logic [SRC_W-1:0]   src_out,
    output logic               pad_out
);

    localparam logic [SRC_W-1:0] LAST = SRC_W'(N_REQ - 1);

    state_t             state;
    state_t             state_nx;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   owner;
    logic [7:0]         hi;
    logic [SRC_W-1:0]   winner;
    logic               found;
    logic [SRC_W-1:0]   sel;
    logic [7:0]         byte_in;
    logic [7:0]         lo_byte;
    logic [SRC_W-1:0]   ptr_nx;
    logic               take_hi;
    logic               emit;

    rr_picker #(
        .N (N_REQ),
        .W (SRC_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .winner    (winner),
        .found     (found)
    );

    assign sel     = (state == IDLE) ? winner : owner;
    assign byte_in = req_data[{sel, 3'b000} +: 8];
    assign ptr_nx  = (owner == LAST) ? '0 : owner + 1'b1;

`ifdef WIDTH_PACK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt;
    logic          pad;

    assign lo_byte = pad ? PAD_BYTE : byte_in;

    // Saturates at the threshold; the word is flushed on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (take_hi)
            cnt <= '0;
        else if (state == HALF && !req_valid[owner] && cnt != TO_MAX)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pad_out <= 1'b0;
        else if (emit)
            pad_out <= pad;
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYC;
    assign lo_byte        = byte_in;
    assign pad_out        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        take_hi   = 1'b0;
        emit      = 1'b0;
`ifdef WIDTH_PACK_ARB_TIMEOUT_EN
        pad       = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    take_hi           = 1'b1;
                    state_nx          = HALF;
                end
            end
            HALF: begin
                req_ready[owner] = 1'b1;
                if (req_valid[owner]) begin
                    emit     = 1'b1;
                    state_nx = IDLE;
                end
`ifdef WIDTH_PACK_ARB_TIMEOUT_EN
                else if (cnt == TO_MAX) begin
                    emit     = 1'b1;
                    pad      = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            hi        <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            src_out   <= '0;
        end else begin
            valid_out <= emit;
            if (take_hi) begin
                hi    <= byte_in;
                owner <= winner;
            end
            if (emit) begin
                data_out <= {hi, lo_byte};
                src_out  <= owner;
                ptr      <= ptr_nx;
            end
        end
    end

endmodule
